// File: rtl/multiport_register_array_pkg.sv
// Shared types and helpers for the multiport register array: FSM state encoding and lane merge.
package regarray_pkg;

    typedef enum logic {RA_IDLE, RA_CLEAR} ra_state_t;

    // Widest word lane_merge handles; callers size-cast in and out.
    localparam int RA_MAX_WIDTH = 256;

    // Bits set in bit_mask come from new_word, the rest keep old_word.
    function automatic logic [RA_MAX_WIDTH-1:0] lane_merge(
        input logic [RA_MAX_WIDTH-1:0] old_word,
        input logic [RA_MAX_WIDTH-1:0] new_word,
        input logic [RA_MAX_WIDTH-1:0] bit_mask
    );
        return (old_word & ~bit_mask) | (new_word & bit_mask);
    endfunction

endpackage

// File: rtl/multiport_register_array_if.sv
// Bus bundle for the multiport register array: clear control, masked write port, packed read ports.
interface multiport_register_array_if #(
    parameter int LOGDEPTH  = 6,
    parameter int WORDWIDTH = 16,
    parameter int NLANES    = 2,
    parameter int NUM_RD    = 2
);
    logic                          clr;
    logic                          busy;
    logic                          cenW;
    logic [LOGDEPTH-1:0]           aW;
    logic [NLANES-1:0]             wmask;
    logic [WORDWIDTH-1:0]          d;
    logic [NUM_RD-1:0]             cenR;
    logic [NUM_RD*LOGDEPTH-1:0]    aR;
    logic [NUM_RD*WORDWIDTH-1:0]   q;
    logic [NUM_RD-1:0]             qValid;

    modport master (
        output clr, cenW, aW, wmask, d, cenR, aR,
        input  busy, q, qValid
    );

    modport slave (
        input  clr, cenW, aW, wmask, d, cenR, aR,
        output busy, q, qValid
    );
endinterface

// File: rtl/multiport_register_array_clear_ctrl.sv
// Clear sweep controller: after rst or clr, walks every entry once writing zero, holding busy meanwhile.
module regarray_clear_ctrl
    import regarray_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int LOGDEPTH = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_clr,
    output logic                o_busy,
    output logic                o_clr_we,
    output logic [LOGDEPTH-1:0] o_clr_addr
);
    localparam logic [LOGDEPTH-1:0] LAST_ADDR = LOGDEPTH'(DEPTH - 1);

    ra_state_t           r_state, w_state_next;
    logic [LOGDEPTH-1:0] r_cnt, w_cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RA_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        o_clr_we     = 1'b0;
        if (i_clr) begin
            // A clear request always restarts the sweep from entry 0.
            w_state_next = RA_CLEAR;
            w_cnt_next   = '0;
        end else begin
            case (r_state)
                RA_CLEAR: begin
                    o_clr_we = 1'b1;
                    if (r_cnt == LAST_ADDR) begin
                        w_state_next = RA_IDLE;
                        w_cnt_next   = '0;
                    end else begin
                        w_cnt_next = r_cnt + LOGDEPTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy     = (r_state == RA_CLEAR);
    assign o_clr_addr = r_cnt;

endmodule

// File: rtl/multiport_register_array.sv
// Register array with one lane-masked write port, NUM_RD registered read ports, valid bits and clear sweep.
// Build option REGFILE_BYPASS_EN: read/write collisions return the merged new word (write-first).
module multiport_register_array
    import regarray_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int LOGDEPTH  = 6,
    parameter int WORDWIDTH = 16,
    parameter int LANEWIDTH = 8,
    parameter int NUM_RD    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    multiport_register_array_if.slave bus
);
    localparam int                NLANES  = WORDWIDTH / LANEWIDTH;
    localparam logic [LOGDEPTH:0] DEPTH_W = (LOGDEPTH + 1)'(DEPTH);

    logic [WORDWIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]     r_valid;

    logic                 w_busy;
    logic                 w_clr_we;
    logic [LOGDEPTH-1:0]  w_clr_addr;
    logic [WORDWIDTH-1:0] w_bit_mask;
    logic [WORDWIDTH-1:0] w_wr_word;
    logic                 w_wr_en;

    regarray_clear_ctrl #(
        .DEPTH    (DEPTH),
        .LOGDEPTH (LOGDEPTH)
    ) u_clear_ctrl (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (bus.clr),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign bus.busy = w_busy;

    generate
        for (genvar gi = 0; gi < NLANES; gi++) begin : g_lane
            assign w_bit_mask[gi*LANEWIDTH +: LANEWIDTH] = {LANEWIDTH{bus.wmask[gi]}};
        end
    endgenerate

    // An all-zero mask or out-of-range address leaves both data and valid untouched.
    assign w_wr_en = !rst && !bus.clr && !w_busy && !bus.cenW
                   && ({1'b0, bus.aW} < DEPTH_W) && (|bus.wmask);

    assign w_wr_word = WORDWIDTH'(lane_merge(RA_MAX_WIDTH'(r_mem[bus.aW]),
                                             RA_MAX_WIDTH'(bus.d),
                                             RA_MAX_WIDTH'(w_bit_mask)));

    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            r_mem[w_clr_addr] <= '0;
        end else if (w_wr_en) begin
            r_mem[bus.aW] <= w_wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.clr) begin
            r_valid <= '0;
        end else if (w_wr_en) begin
            r_valid[bus.aW] <= 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [LOGDEPTH-1:0]  w_addr;
            logic                 w_in_range;
            logic                 w_hit;
            logic [WORDWIDTH-1:0] r_q;
            logic                 r_q_valid;

            assign w_addr     = bus.aR[gi*LOGDEPTH +: LOGDEPTH];
            assign w_in_range = ({1'b0, w_addr} < DEPTH_W);
`ifdef REGFILE_BYPASS_EN
            assign w_hit = w_wr_en && (w_addr == bus.aW);
`else
            assign w_hit = 1'b0;
`endif

            // clr and a disabled port both hold; only rst forces the output register to zero.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_q       <= '0;
                    r_q_valid <= 1'b0;
                end else if (!bus.clr && !bus.cenR[gi]) begin
                    if (w_busy || !w_in_range) begin
                        r_q       <= '0;
                        r_q_valid <= 1'b0;
                    end else if (w_hit) begin
                        r_q       <= w_wr_word;
                        r_q_valid <= 1'b1;
                    end else begin
                        r_q       <= r_mem[w_addr];
                        r_q_valid <= r_valid[w_addr];
                    end
                end
            end

            assign bus.q[gi*WORDWIDTH +: WORDWIDTH] = r_q;
            assign bus.qValid[gi]                   = r_q_valid;
        end
    endgenerate

endmodule

// File: tb/tb_multiport_register_array.sv
// Drives a 16-entry and a 12-entry array with identical stimulus and checks both against a behavioural model.
module tb_multiport_register_array;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        s_rst, s_clr, s_cenW;
    logic [3:0]  s_aW;
    logic [1:0]  s_wmask;
    logic [15:0] s_d;
    logic [1:0]  s_cenR;
    logic [7:0]  s_aR;

    int n_cmp  = 0;
    int n_fail = 0;

    multiport_register_array_if #(.LOGDEPTH(4), .WORDWIDTH(16), .NLANES(2), .NUM_RD(2)) bus16 ();
    multiport_register_array_if #(.LOGDEPTH(4), .WORDWIDTH(16), .NLANES(2), .NUM_RD(2)) bus12 ();

    assign bus16.clr = s_clr;   assign bus12.clr = s_clr;
    assign bus16.cenW = s_cenW; assign bus12.cenW = s_cenW;
    assign bus16.aW = s_aW;     assign bus12.aW = s_aW;
    assign bus16.wmask = s_wmask; assign bus12.wmask = s_wmask;
    assign bus16.d = s_d;       assign bus12.d = s_d;
    assign bus16.cenR = s_cenR; assign bus12.cenR = s_cenR;
    assign bus16.aR = s_aR;     assign bus12.aR = s_aR;

    multiport_register_array #(.DEPTH(16), .LOGDEPTH(4), .WORDWIDTH(16), .LANEWIDTH(8), .NUM_RD(2))
        u16 (.clk(clk), .rst(s_rst), .bus(bus16));
    multiport_register_array #(.DEPTH(12), .LOGDEPTH(4), .WORDWIDTH(16), .LANEWIDTH(8), .NUM_RD(2))
        u12 (.clk(clk), .rst(s_rst), .bus(bus12));

    logic        dut_busy [2];
    logic [31:0] dut_q    [2];
    logic [1:0]  dut_qv   [2];
    assign dut_busy[0] = bus16.busy;  assign dut_busy[1] = bus12.busy;
    assign dut_q[0]    = bus16.q;     assign dut_q[1]    = bus12.q;
    assign dut_qv[0]   = bus16.qValid; assign dut_qv[1]  = bus12.qValid;

    // Reference model: memory contents as seen after a completed sweep, plus remaining sweep cycles.
    logic [15:0] m_mem [2][16];
    bit          m_val [2][16];
    logic [15:0] m_q   [2][2];
    bit          m_qv  [2][2];
    int          m_rem [2];
    bit          m_live = 1'b0;

    function automatic int dep_of(input int k);
        return (k == 0) ? 16 : 12;
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old_w, input logic [15:0] new_w,
                                          input logic [1:0] mask);
        logic [15:0] r;
        r = old_w;
        if (mask[0]) r[7:0]  = new_w[7:0];
        if (mask[1]) r[15:8] = new_w[15:8];
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        int dep;
        int a;
        bit wr_ok;
        dep = dep_of(k);
        if (s_rst || s_clr) begin
            for (int i = 0; i < 16; i++) begin
                m_mem[k][i] = 16'h0;
                m_val[k][i] = 1'b0;
            end
            m_rem[k] = dep;
            if (s_rst) begin
                for (int p = 0; p < 2; p++) begin
                    m_q[k][p]  = 16'h0;
                    m_qv[k][p] = 1'b0;
                end
            end
        end else if (m_rem[k] > 0) begin
            m_rem[k]--;
            for (int p = 0; p < 2; p++) begin
                if (!s_cenR[p]) begin
                    m_q[k][p]  = 16'h0;
                    m_qv[k][p] = 1'b0;
                end
            end
        end else begin
            wr_ok = !s_cenW && (int'(s_aW) < dep) && (s_wmask != 2'b00);
            for (int p = 0; p < 2; p++) begin
                if (!s_cenR[p]) begin
                    a = int'(s_aR[p*4 +: 4]);
                    if (a >= dep) begin
                        m_q[k][p]  = 16'h0;
                        m_qv[k][p] = 1'b0;
                    end else if (BYPASS && wr_ok && a == int'(s_aW)) begin
                        m_q[k][p]  = merge(m_mem[k][a], s_d, s_wmask);
                        m_qv[k][p] = 1'b1;
                    end else begin
                        m_q[k][p]  = m_mem[k][a];
                        m_qv[k][p] = m_val[k][a];
                    end
                end
            end
            if (wr_ok) begin
                m_mem[k][s_aW] = merge(m_mem[k][s_aW], s_d, s_wmask);
                m_val[k][s_aW] = 1'b1;
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_step(k);
        if (s_rst) m_live = 1'b1;
    end

    initial forever begin
        @(negedge clk);
        if (m_live) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("model_busy_d%0d", dep_of(k)), 32'(dut_busy[k]), 32'(m_rem[k] > 0));
                for (int p = 0; p < 2; p++) begin
                    check($sformatf("model_q%0d_d%0d", p, dep_of(k)),
                          32'(dut_q[k][p*16 +: 16]), 32'(m_q[k][p]));
                    check($sformatf("model_qv%0d_d%0d", p, dep_of(k)),
                          32'(dut_qv[k][p]), 32'(m_qv[k][p]));
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        s_rst = 1'b0; s_clr = 1'b0; s_cenW = 1'b1; s_aW = 4'd0;
        s_wmask = 2'b00; s_d = 16'h0; s_cenR = 2'b11; s_aR = 8'h00;
    endtask

    task automatic wait_busy_len(input string name, input int expected);
        int n;
        n = 0;
        while (bus16.busy === 1'b1 && n < 100) begin
            n++;
            step();
        end
        check(name, 32'(n), 32'(expected));
    endtask

    initial begin
        int n;
        idle();
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        // 1: reset, sweep length, write during busy dropped
        check("t1_busy_after_rst", 32'(bus16.busy), 32'd1);
        check("t1_q_after_rst", bus16.q, 32'h0);
        n = 0;
        while (bus16.busy === 1'b1 && n < 100) begin
            if (n == 2) begin
                s_cenW = 1'b0; s_aW = 4'd3; s_d = 16'hBEEF; s_wmask = 2'b11;
            end else begin
                s_cenW = 1'b1;
            end
            n++;
            step();
        end
        s_cenW = 1'b1;
        check("t1_busy_len", 32'(n), 32'd16);
        s_cenR = 2'b10; s_aR = {4'd0, 4'd3};
        step();
        check("t1_q0_addr3", 32'(bus16.q[15:0]), 32'h0000);
        check("t1_qv0_addr3", 32'(bus16.qValid[0]), 32'd0);
        s_cenR = 2'b11;

        // 2: lane-masked overwrite
        s_cenW = 1'b0; s_aW = 4'd5; s_d = 16'hA1B2; s_wmask = 2'b11;
        step();
        s_d = 16'hFFFF; s_wmask = 2'b01;
        step();
        s_cenW = 1'b1; s_cenR = 2'b10; s_aR = {4'd0, 4'd5};
        step();
        check("t2_q0_merged", 32'(bus16.q[15:0]), 32'hA1FF);
        check("t2_qv0", 32'(bus16.qValid[0]), 32'd1);

        // 3: read/write collision on port 1
        s_cenW = 1'b0; s_aW = 4'd7; s_d = 16'h1234; s_wmask = 2'b11;
        s_cenR = 2'b01; s_aR = {4'd7, 4'd0};
        step();
        s_cenW = 1'b1; s_cenR = 2'b11;
        check("t3_q1_collide", 32'(bus16.q[31:16]), BYPASS ? 32'h1234 : 32'h0000);
        check("t3_qv1_collide", 32'(bus16.qValid[1]), BYPASS ? 32'd1 : 32'd0);
        check("t3_q0_hold", 32'(bus16.q[15:0]), 32'hA1FF);

        // 4: two ports, then hold, then same address
        s_cenR = 2'b00; s_aR = {4'd9, 4'd5};
        step();
        s_cenR = 2'b11; s_aR = {4'd3, 4'd3};
        check("t4_q_pair", bus16.q, {16'h0000, 16'hA1FF});
        check("t4_qv_pair", 32'(bus16.qValid), 32'b01);
        step();
        check("t4_q_hold", bus16.q, {16'h0000, 16'hA1FF});
        check("t4_qv_hold", 32'(bus16.qValid), 32'b01);
        s_cenR = 2'b00; s_aR = {4'd7, 4'd7};
        step();
        s_cenR = 2'b11;
        check("t4_q_same", bus16.q, {16'h1234, 16'h1234});
        check("t4_qv_same", 32'(bus16.qValid), 32'b11);

        // 5: clr restart mid-sweep, then rst+clr together
        s_clr = 1'b1;
        step();
        s_clr = 1'b0;
        check("t5_busy_after_clr", 32'(bus16.busy), 32'd1);
        check("t5_q_hold_clr", bus16.q, {16'h1234, 16'h1234});
        repeat (8) step();
        s_clr = 1'b1;
        step();
        s_clr = 1'b0;
        wait_busy_len("t5_restart_len", 16);
        s_cenR = 2'b00; s_aR = {4'd7, 4'd5};
        step();
        s_cenR = 2'b11;
        check("t5_q_after_clr", bus16.q, 32'h0);
        check("t5_qv_after_clr", 32'(bus16.qValid), 32'b00);
        s_cenW = 1'b0; s_aW = 4'd5; s_d = 16'hCAFE; s_wmask = 2'b11;
        step();
        s_cenW = 1'b1; s_cenR = 2'b10; s_aR = {4'd0, 4'd5};
        step();
        s_cenR = 2'b11;
        check("t5_q0_cafe", 32'(bus16.q[15:0]), 32'hCAFE);
        s_rst = 1'b1; s_clr = 1'b1;
        step();
        s_rst = 1'b0; s_clr = 1'b0;
        check("t5_rstclr_q0", 32'(bus16.q[15:0]), 32'h0);
        check("t5_rstclr_qv0", 32'(bus16.qValid[0]), 32'd0);
        wait_busy_len("t5_rstclr_len", 16);

        // 6: out-of-range accesses on the 12-entry array
        s_cenW = 1'b0; s_aW = 4'd13; s_d = 16'h5555; s_wmask = 2'b11;
        step();
        s_cenW = 1'b1; s_cenR = 2'b00; s_aR = {4'd13, 4'd14};
        step();
        check("t6_d12_q", bus12.q, 32'h0);
        check("t6_d12_qv", 32'(bus12.qValid), 32'b00);
        check("t6_d16_q1", 32'(bus16.q[31:16]), 32'h5555);
        check("t6_d16_qv", 32'(bus16.qValid), 32'b10);
        s_aR = {4'd1, 4'd1};
        step();
        s_cenR = 2'b11;
        check("t6_d12_alias_q", bus12.q, 32'h0);
        check("t6_d12_alias_qv", 32'(bus12.qValid), 32'b00);

        // Random traffic; the per-cycle compare process checks it against the model.
        for (int i = 0; i < 2000; i++) begin
            s_rst   = ($urandom_range(0, 499) == 0);
            s_clr   = ($urandom_range(0, 149) == 0);
            s_cenW  = ($urandom_range(0, 3) == 0);
            s_aW    = 4'($urandom_range(0, 15));
            s_wmask = 2'($urandom);
            s_d     = 16'($urandom);
            s_cenR  = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                s_aR[p*4 +: 4] = ($urandom_range(0, 1) == 0) ? s_aW : 4'($urandom_range(0, 15));
            end
            step();
        end
        idle();
        repeat (3) step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
